// File: rtl/classificar_ativo_par_pkg.sv
// Shared encodings and helpers for the parallel active-node classifier.
package classificar_ativo_par_pkg;

  localparam int unsigned MODO_MIN = 0;
  localparam int unsigned MODO_MAX = 1;

  typedef enum logic {
    OCIOSO = 1'b0,
    VARRE  = 1'b1
  } estado_t;

  // Number of scan passes needed to cover all nodes.
  function automatic int unsigned calc_npass(input int unsigned num_na, input int unsigned lanes);
    return (num_na + lanes - 1) / lanes;
  endfunction

  // Sentinel that loses every strict comparison in the chosen mode.
  function automatic logic [31:0] calc_sent(input int unsigned cw, input int unsigned modo);
    logic [63:0] w_um;
    w_um = 64'd1;
    if (modo == MODO_MAX) return 32'd0;
    return 32'((w_um << cw) - 64'd1);
  endfunction

endpackage

// File: rtl/classificar_ativo_par_selecao_arvore.sv
// Combinational LANES-input reduction tree selecting the extreme valid criterion.
module selecao_arvore
  import classificar_ativo_par_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned CW    = 5,
  parameter int unsigned IW    = 3,
  parameter int unsigned MODO  = 0
) (
  input  logic [LANES-1:0]    i_valido,
  input  logic [LANES*CW-1:0] i_criterio,
  input  logic [LANES*IW-1:0] i_indice,
  output logic                o_valido_c,
  output logic [CW-1:0]       o_criterio_c,
  output logic [IW-1:0]       o_indice_c
);

  localparam int unsigned LV = $clog2(LANES);
  localparam int unsigned P  = 1 << LV;
  localparam int unsigned N  = 2 * P - 1;

  logic          w_v [N];
  logic [CW-1:0] w_c [N];
  logic [IW-1:0] w_i [N];

  // Heap layout: leaves at P-1.., left child always holds the lower indices.
  always_comb begin
    for (int l = 0; l < int'(P); l++) begin
      if (l < int'(LANES)) begin
        w_v[int'(P) - 1 + l] = i_valido[l];
        w_c[int'(P) - 1 + l] = i_criterio[l*int'(CW) +: int'(CW)];
        w_i[int'(P) - 1 + l] = i_indice[l*int'(IW) +: int'(IW)];
      end else begin
        w_v[int'(P) - 1 + l] = 1'b0;
        w_c[int'(P) - 1 + l] = '0;
        w_i[int'(P) - 1 + l] = '0;
      end
    end
    for (int k = 0; k < int'(P) - 1; k++) begin
      int  n;
      int  a;
      int  b;
      logic w_b_melhor;
      n = int'(P) - 2 - k;
      a = 2 * n + 1;
      b = 2 * n + 2;
      if (MODO == MODO_MAX) w_b_melhor = w_v[b] && (!w_v[a] || (w_c[b] > w_c[a]));
      else                  w_b_melhor = w_v[b] && (!w_v[a] || (w_c[b] < w_c[a]));
      w_v[n] = w_v[a] | w_v[b];
      w_c[n] = w_b_melhor ? w_c[b] : w_c[a];
      w_i[n] = w_b_melhor ? w_i[b] : w_i[a];
    end
  end

  assign o_valido_c   = w_v[0];
  assign o_criterio_c = w_c[0];
  assign o_indice_c   = w_i[0];

endmodule

// File: rtl/classificar_ativo_par.sv
// Snapshot-based multi-lane classifier: finds the extreme criterion among active nodes.
module classificar_ativo_par
  import classificar_ativo_par_pkg::*;
#(
  parameter int unsigned NUM_NA         = 8,
  parameter int unsigned CRITERIO_WIDTH = 5,
  parameter int unsigned LANES          = 2,
  parameter int unsigned MODO_MAX       = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             aa_atualizar_in,
  input  logic [NUM_NA-1:0]                na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
  output logic                             ca_ocupado_o,
  output logic                             ca_pronto_o,
  output logic                             ca_vazio_o,
  output logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_out,
  output logic [$clog2(NUM_NA)-1:0]        ca_indice_out
);

  localparam int unsigned CW    = CRITERIO_WIDTH;
  localparam int unsigned IW    = $clog2(NUM_NA);
  localparam int unsigned NPASS = calc_npass(NUM_NA, LANES);
  localparam int unsigned NPAD  = NPASS * LANES;
  localparam int unsigned PW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [CW-1:0] SENT = CW'(calc_sent(CW, MODO_MAX));

  estado_t                r_estado;
  logic [PW-1:0]          r_pass;
  logic [NUM_NA-1:0]      r_ativo;
  logic [NUM_NA*CW-1:0]   r_criterio;

  logic [NPAD-1:0]        w_ativo_pad;
  logic [NPAD*CW-1:0]     w_crit_pad;
  logic [LANES-1:0]       w_lane_val;
  logic [LANES*CW-1:0]    w_lane_crit;
  logic [LANES*IW-1:0]    w_lane_idx;
  logic                   w_arv_val;
  logic [CW-1:0]          w_arv_crit;
  logic [IW-1:0]          w_arv_idx;
  logic                   w_substitui;

  // Nodes beyond NUM_NA are padding and never valid.
  for (genvar n = 0; n < NPAD; n++) begin : g_pad
    if (n < NUM_NA) begin : g_real
      assign w_ativo_pad[n]          = r_ativo[n];
      assign w_crit_pad[n*CW +: CW]  = r_criterio[n*CW +: CW];
    end else begin : g_vazio
      assign w_ativo_pad[n]          = 1'b0;
      assign w_crit_pad[n*CW +: CW]  = '0;
    end
  end

  always_comb begin
    w_lane_val  = '0;
    w_lane_crit = '0;
    w_lane_idx  = '0;
    for (int p = 0; p < int'(NPASS); p++) begin
      if (r_pass == PW'(p)) begin
        w_lane_val  = w_ativo_pad[p*int'(LANES) +: int'(LANES)];
        w_lane_crit = w_crit_pad[p*int'(LANES*CW) +: int'(LANES*CW)];
        for (int l = 0; l < int'(LANES); l++)
          w_lane_idx[l*int'(IW) +: int'(IW)] = IW'(p*int'(LANES) + l);
      end
    end
  end

  selecao_arvore #(
    .LANES (LANES),
    .CW    (CW),
    .IW    (IW),
    .MODO  (MODO_MAX)
  ) u_arvore (
    .i_valido     (w_lane_val),
    .i_criterio   (w_lane_crit),
    .i_indice     (w_lane_idx),
    .o_valido_c   (w_arv_val),
    .o_criterio_c (w_arv_crit),
    .o_indice_c   (w_arv_idx)
  );

  // Running best keeps ties, since earlier passes carry lower indices.
  always_comb begin
    w_substitui = 1'b0;
    if (w_arv_val) begin
      if (ca_vazio_o)               w_substitui = 1'b1;
      else if (MODO_MAX == MODO_MAX_C()) w_substitui = (w_arv_crit > ca_criterio_geral_out);
      else                          w_substitui = (w_arv_crit < ca_criterio_geral_out);
    end
  end

  function automatic int unsigned MODO_MAX_C();
    return classificar_ativo_par_pkg::MODO_MAX;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado              <= OCIOSO;
      r_pass                <= '0;
      r_ativo               <= '0;
      r_criterio            <= '0;
      ca_ocupado_o          <= 1'b0;
      ca_pronto_o           <= 1'b0;
      ca_vazio_o            <= 1'b1;
      ca_criterio_geral_out <= SENT;
      ca_indice_out         <= '0;
    end else if (aa_atualizar_in) begin
      r_estado              <= VARRE;
      r_pass                <= '0;
      r_ativo               <= na_ativo_in;
      r_criterio            <= na_criterio_in;
      ca_ocupado_o          <= 1'b1;
      ca_pronto_o           <= 1'b0;
      ca_vazio_o            <= 1'b1;
      ca_criterio_geral_out <= SENT;
      ca_indice_out         <= '0;
    end else if (r_estado == VARRE) begin
      if (w_substitui) begin
        ca_vazio_o            <= 1'b0;
        ca_criterio_geral_out <= w_arv_crit;
        ca_indice_out         <= w_arv_idx;
      end
      if (r_pass == PW'(NPASS - 1)) begin
        r_estado     <= OCIOSO;
        r_pass       <= '0;
        ca_ocupado_o <= 1'b0;
        ca_pronto_o  <= 1'b1;
      end else begin
        r_pass <= r_pass + PW'(1);
      end
    end
  end

endmodule

// File: doc/classificar_ativo_par.md
# classificar_ativo_par

Parametrised successor to the serial active-node classifier. On a start pulse it captures a snapshot of the per-node criteria and active mask. It then scans LANES nodes per cycle through a comparator tree and reports the extreme criterion (minimum or maximum) among active nodes, its node index, and an empty flag. It sits between the node-array update logic (aa_*) and the scheduler that consumes ca_* results.

## Interface
- NUM_NA, 8: number of nodes, ≥2
- CRITERIO_WIDTH, 5: criterion width, bits
- LANES, 2: nodes compared per cycle, 1..NUM_NA
- MODO_MAX, 0: 0 = select minimum, 1 = select maximum
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- aa_atualizar_in  in  1  start pulse; samples inputs
- na_ativo_in  in  NUM_NA  active mask, bit i = node i
- na_criterio_in  in  NUM_NA*CRITERIO_WIDTH  packed criteria, node i at [CW*i +: CW]
- ca_ocupado_o  out  1  scan in progress
- ca_pronto_o  out  1  result valid (level)
- ca_vazio_o  out  1  no active node in snapshot
- ca_criterio_geral_out  out  CRITERIO_WIDTH  selected criterion
- ca_indice_out  out  $clog2(NUM_NA)  index of selected node

## Operation
- Derived constants: NPASS = ceil(NUM_NA/LANES); SENT = all-ones when MODO_MAX=0, zero when MODO_MAX=1.
- States:
  - OCIOSO: waits for aa_atualizar_in=1; then loads the snapshot, sets best=SENT, vazio=1, pass=0, and goes to VARRE.
  - VARRE: each cycle evaluates nodes pass*LANES .. pass*LANES+LANES-1 and merges them into the running best. After pass NPASS-1 it goes to OCIOSO.
- Lanes whose index is ≥NUM_NA are treated as inactive (padding).
- Only active nodes participate; inactive nodes never affect the outputs.
- Strict comparison: "<" for minimum, ">" for maximum.
- Ties go to the lower index, both inside the tree and against the running best.
- Empty result: ca_vazio_o=1, criterio=SENT, indice=0.
- aa_atualizar_in while in VARRE aborts the scan and restarts with a fresh snapshot. The in-flight result is discarded.
- Live inputs are ignored except at the start edge.
- Outputs hold until the next start.

## Timing
- Reset values: ocupado=0, pronto=0, vazio=1, criterio=SENT, indice=0. pass counter=0, state=OCIOSO.
- Start sampled at edge E0:
  - pronto and ocupado change at E0: pronto falls, ocupado rises.
  - Pass k is registered at E(k+1).
  - At E(NPASS): final result registered, ocupado falls, pronto rises.
- Start-to-pronto latency = NPASS cycles (4 for defaults). Back-to-back starts are legal.
- Intermediate values of criterio and indice may be visible while ocupado=1. Consumers qualify on pronto.
- Reset asserted mid-scan: all state returns to reset values immediately. No pronto until a new start.
- Comparator tree is combinational within one cycle, depth $clog2(LANES). The pass counter wraps only through the state transition, never arithmetically.

## Structure
- Shared package holds the mode encoding (MODO_MIN=0, MODO_MAX=1), the state encoding (OCIOSO, VARRE), and the NPASS/SENT helper functions.
- One sub-module, selecao_arvore: combinational LANES-input reduction tree.
  - Per lane inputs: valid, criterion, index.
  - Outputs: valid, criterion, index.
  - Same mode and tie rules as the top level.
- Top level holds the snapshot registers, pass counter, FSM, and running-best merge.

## Test plan
Defaults unless noted: NUM_NA=8, LANES=2, CW=5.
- Reset → ocupado=0, pronto=0, vazio=1, criterio=31, indice=0.
- Criteria idx0..7 = [9,3,7,3,12,1,20,5], ativo=8'b11011110, start → 4 cycles later pronto=1, criterio=3, indice=1, vazio=0. Node 5 (value 1) is inactive, and the tie between idx1 and idx3 resolves to idx1.
- Same criteria, ativo=0 → pronto after 4 cycles, vazio=1, criterio=31, indice=0.
- Scenario 2 inputs changed to all-active criterio=2 on the cycle after start → result still criterio=3, indice=1, because the snapshot holds.
- Start, then a second start 2 cycles later with ativo=8'h80 → pronto only 4 cycles after the second start, criterio=5, indice=7. No intermediate pronto.
- NUM_NA=5, LANES=2, MODO_MAX=1, criteria [4,17,17,2,9], all active → pronto after 3 cycles, criterio=17, indice=1. Rerun with reset asserted at cycle 1 → all outputs return to reset values, pronto stays 0.
